// File: rtl/riscv_pkg.sv
// Shared core constants and small enums used by the writeback path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;

    // Which producer won the most recent contended arbitration.
    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LSU = 1'b1
    } grant_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter (a = ALU, b = LSU) with a 1-bit history.
// Latency: grants are combinational from requests and the history register.
// Backpressure: the loser of a contended cycle is favoured on the next contention.
module rr_arbiter2
    import riscv_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    grant_e last_grant_q;
    grant_e last_grant_d;

    // Grant decision; history only moves when both producers were competing.
    always_comb begin
        last_grant_d = last_grant_q;
        gnt_a        = rst_n && req_a && (!req_b || (last_grant_q == GNT_LSU));
        gnt_b        = rst_n && req_b && (!req_a || (last_grant_q == GNT_ALU));
        if (req_a && req_b) begin
            last_grant_d = gnt_a ? GNT_ALU : GNT_LSU;
        end
    end

    // History register; reset value makes the LSU win the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= GNT_ALU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU/LSU results onto one RF write port and tracks pending writes.
// Latency: 1 cycle from accepted result to write_enable; busy bits update on the next edge.
// Backpressure: issue stalls on WAW hazards; the losing producer is held off by its ready.
module writeback_unit
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic [REG_AW-1:0]     issue_rd,
    output logic                  issue_ready,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_AW-1:0]     alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_AW-1:0]     lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  write_enable,
    output logic [REG_AW-1:0]     write_reg,
    output logic [XLEN-1:0]       write_data,
    input  logic [REG_AW-1:0]     chk_rs1,
    input  logic [REG_AW-1:0]     chk_rs2,
    output logic                  busy_rs1,
    output logic                  busy_rs2
);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_t;

    logic [NREGS-1:0] busy_q, busy_d;
    logic             write_enable_q, write_enable_d;
    wb_t              wb_q, wb_d;
    wb_t              sel;
    logic             xfer;
    logic             issue_fire;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_a (alu_valid),
        .req_b (lsu_valid),
        .gnt_a (alu_ready),
        .gnt_b (lsu_ready)
    );

    // Hazard check and scoreboard queries read the registered busy bits only.
    always_comb begin
        issue_ready = rst_n && !((issue_rd != '0) && busy_q[issue_rd]);
        issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
        busy_rs1    = busy_q[chk_rs1];
        busy_rs2    = busy_q[chk_rs2];
    end

    // Select the granted result and form the next write-port contents; rd=0 results are dropped.
    always_comb begin
        sel            = lsu_ready ? wb_t'{rd: lsu_rd, data: lsu_data}
                                   : wb_t'{rd: alu_rd, data: alu_data};
        xfer           = (alu_valid && alu_ready) || (lsu_valid && lsu_ready);
        write_enable_d = xfer && (sel.rd != '0);
        wb_d           = write_enable_d ? sel : wb_q;
    end

    // Scoreboard update: retire the write in flight, then set on issue so a same-edge set wins.
    always_comb begin
        busy_d = busy_q;
        if (write_enable_q) begin
            busy_d[wb_q.rd] = 1'b0;
        end
        if (issue_fire) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers; reset discards any write that was about to appear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q         <= '0;
            write_enable_q <= 1'b0;
            wb_q           <= '0;
        end else begin
            busy_q         <= busy_d;
            write_enable_q <= write_enable_d;
            wb_q           <= wb_d;
        end
    end

    assign write_enable = write_enable_q;
    assign write_reg    = wb_q.rd;
    assign write_data   = wb_q.data;

endmodule
